// File: rtl/cpu_pkg.sv
// Shared types and constants for the cpu control path.
// Instruction word is {opcode, rd, rs1, rs2}, rs2 in the low bits.
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_OPA,
    S_OPB,
    S_EXEC,
    S_AWAIT,
    S_WB,
    S_DONE
  } state_t;

  localparam logic [1:0] PH_LOAD = 2'b00;
  localparam logic [1:0] PH_EXEC = 2'b01;
  localparam logic [1:0] PH_OUT  = 2'b10;
  localparam logic [1:0] PH_IDLE = 2'b11;

  localparam int DEF_DATA_W  = 4;
  localparam int DEF_RADDR_W = 2;
  localparam int DEF_OP_W    = 3;
  localparam int DEF_PC_W    = 4;

  function automatic int inst_w(
    input int op_w,
    input int raddr_w
  );
    return op_w + 3 * raddr_w;
  endfunction

  function automatic int rs2_lsb(input int raddr_w);
    return 0 * raddr_w;
  endfunction

  function automatic int rs1_lsb(input int raddr_w);
    return raddr_w;
  endfunction

  function automatic int rd_lsb(input int raddr_w);
    return 2 * raddr_w;
  endfunction

  function automatic int op_lsb(input int raddr_w);
    return 3 * raddr_w;
  endfunction

  localparam int DEF_INST_W = inst_w(DEF_OP_W, DEF_RADDR_W);

endpackage

// File: rtl/cpu_sequencer.sv
// Multi-cycle control FSM: fetch, read two operands, run ALU, write back.
// Six cycles per instruction through a single-port register file.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int RADDR_W = DEF_RADDR_W,
  parameter int OP_W    = DEF_OP_W,
  parameter int PC_W    = DEF_PC_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [PC_W-1:0]             prog_len,
  output logic [PC_W-1:0]             inst_addr,
  input  logic [OP_W+3*RADDR_W-1:0]   inst_data,
  output logic [RADDR_W-1:0]          reg_addr,
  input  logic [DATA_W-1:0]           reg_rdata,
  output logic                        reg_wr_en,
  output logic [DATA_W-1:0]           reg_wdata,
  output logic                        alu_en,
  output logic [OP_W-1:0]             alu_opcode,
  output logic [DATA_W-1:0]           alu_in_1,
  output logic [DATA_W-1:0]           alu_in_2,
  input  logic [DATA_W-1:0]           alu_out,
  output logic [1:0]                  phase,
  output logic                        busy,
  output logic                        done,
  output logic [DATA_W-1:0]           result
);

  localparam int INST_W  = inst_w(OP_W, RADDR_W);
  localparam int RS2_LSB = rs2_lsb(RADDR_W);
  localparam int RS1_LSB = rs1_lsb(RADDR_W);
  localparam int RD_LSB  = rd_lsb(RADDR_W);
  localparam int OP_LSB  = op_lsb(RADDR_W);

  state_t              state_q, state_d;
  logic [PC_W-1:0]     pc_q;
  logic [PC_W-1:0]     len_q;
  logic [INST_W-1:0]   ir_q;
  logic [DATA_W-1:0]   op_a_q;
  logic [DATA_W-1:0]   op_b_q;
  logic [DATA_W-1:0]   res_q;
  logic [DATA_W-1:0]   result_q;

  logic [RADDR_W-1:0]  ir_rd;
  logic [RADDR_W-1:0]  ir_rs1;
  logic [RADDR_W-1:0]  ir_rs2;
  logic                last_inst;

  assign ir_rd  = ir_q[RD_LSB  +: RADDR_W];
  assign ir_rs1 = ir_q[RS1_LSB +: RADDR_W];
  assign ir_rs2 = ir_q[RS2_LSB +: RADDR_W];

  // len_q is never zero once WB is reached
  assign last_inst = (pc_q == len_q - PC_W'(1));

  assign inst_addr  = pc_q;
  assign alu_opcode = ir_q[OP_LSB +: OP_W];
  assign alu_in_1   = op_a_q;
  assign alu_in_2   = op_b_q;
  assign result     = result_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase     = PH_LOAD;
    busy      = 1'b1;
    done      = 1'b0;
    alu_en    = 1'b0;
    reg_wr_en = 1'b0;
    reg_addr  = '0;
    reg_wdata = '0;
    unique case (state_q)
      S_IDLE: begin
        phase = PH_IDLE;
        busy  = 1'b0;
        if (start) begin
          state_d = (prog_len != '0) ? S_FETCH : S_DONE;
        end
      end
      S_FETCH: begin
        state_d = S_OPA;
      end
      S_OPA: begin
        reg_addr = ir_rs1;
        state_d  = S_OPB;
      end
      S_OPB: begin
        reg_addr = ir_rs2;
        state_d  = S_EXEC;
      end
      S_EXEC: begin
        phase   = PH_EXEC;
        alu_en  = 1'b1;
        state_d = S_AWAIT;
      end
      S_AWAIT: begin
        phase   = PH_EXEC;
        state_d = S_WB;
      end
      S_WB: begin
        phase     = PH_EXEC;
        reg_wr_en = 1'b1;
        reg_addr  = ir_rd;
        reg_wdata = res_q;
        state_d   = last_inst ? S_DONE : S_FETCH;
      end
      S_DONE: begin
        phase   = PH_OUT;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q     <= '0;
      len_q    <= '0;
      ir_q     <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      res_q    <= '0;
      result_q <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            len_q <= prog_len;
            pc_q  <= '0;
          end
        end
        S_FETCH: ir_q   <= inst_data;
        S_OPA:   op_a_q <= reg_rdata;
        S_OPB:   op_b_q <= reg_rdata;
        S_AWAIT: res_q  <= alu_out;
        S_WB: begin
          result_q <= res_q;
          if (!last_inst) begin
            pc_q <= pc_q + PC_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer with behavioural imem, regfile, ALU.
// Expected write-backs and done cycles are queued at launch time.
module tb_cpu_sequencer;
  import cpu_pkg::*;

  localparam int DW = 4;
  localparam int AW = 2;
  localparam int OW = 3;
  localparam int PW = 4;
  localparam int IW = 9;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [PW-1:0] prog_len = '0;
  logic [PW-1:0] inst_addr;
  logic [IW-1:0] inst_data;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] reg_rdata;
  logic          reg_wr_en;
  logic [DW-1:0] reg_wdata;
  logic          alu_en;
  logic [OW-1:0] alu_opcode;
  logic [DW-1:0] alu_in_1;
  logic [DW-1:0] alu_in_2;
  logic [DW-1:0] alu_out = '0;
  logic [1:0]    phase;
  logic          busy;
  logic          done;
  logic [DW-1:0] result;

  cpu_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
    .inst_addr(inst_addr), .inst_data(inst_data),
    .reg_addr(reg_addr), .reg_rdata(reg_rdata),
    .reg_wr_en(reg_wr_en), .reg_wdata(reg_wdata),
    .alu_en(alu_en), .alu_opcode(alu_opcode),
    .alu_in_1(alu_in_1), .alu_in_2(alu_in_2), .alu_out(alu_out),
    .phase(phase), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  logic [IW-1:0] imem [16];
  logic [DW-1:0] regs [4];
  logic [DW-1:0] mregs [4];

  assign inst_data = imem[inst_addr];
  assign reg_rdata = regs[reg_addr];

  function automatic logic [DW-1:0] alu_f(
    input logic [OW-1:0] op,
    input logic [DW-1:0] a,
    input logic [DW-1:0] b
  );
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return a + 4'd1;
      default: return b;
    endcase
  endfunction

  always @(posedge clk) begin
    if (reg_wr_en) regs[reg_addr] <= reg_wdata;
    if (alu_en) alu_out <= alu_f(alu_opcode, alu_in_1, alu_in_2);
  end

  typedef struct {
    int addr;
    int data;
    int pc;
    int cyc;
  } wb_t;

  wb_t wb_q[$];
  int  done_q[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int alu_cnt = 0;
  int busy_cnt = 0;
  int max_pc = 0;
  int exp_result = 0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    wb_t e;
    if (busy) busy_cnt++;
    if (alu_en) alu_cnt++;
    if (busy && int'(inst_addr) > max_pc) max_pc = int'(inst_addr);
    if (reg_wr_en) begin
      check("wb_expected", 32'(wb_q.size() > 0), 1);
      if (wb_q.size() > 0) begin
        e = wb_q.pop_front();
        check("wb_addr", 32'(reg_addr), e.addr);
        check("wb_data", 32'(reg_wdata), e.data);
        check("wb_pc", 32'(inst_addr), e.pc);
        check("wb_cyc", cyc, e.cyc);
      end
    end
    if (done) begin
      done_cnt++;
      check("done_expected", 32'(done_q.size() > 0), 1);
      if (done_q.size() > 0) check("done_cyc", cyc, done_q.pop_front());
    end
  end

  task automatic set_reg(input int r, input logic [DW-1:0] v);
    regs[r]  = v;
    mregs[r] = v;
  endtask

  task automatic launch(input int len, input bit commit);
    int c;
    logic [DW-1:0] tm [4];
    logic [IW-1:0] w;
    logic [DW-1:0] r;
    wb_t e;
    @(negedge clk);
    c = cyc;
    for (int k = 0; k < 4; k++) tm[k] = mregs[k];
    for (int i = 0; i < len; i++) begin
      w = imem[i];
      r = alu_f(w[8:6], tm[w[3:2]], tm[w[1:0]]);
      tm[w[5:4]] = r;
      e.addr = int'(w[5:4]);
      e.data = int'(r);
      e.pc   = i;
      e.cyc  = c + 6 * (i + 1);
      wb_q.push_back(e);
      if (commit) exp_result = int'(r);
    end
    if (commit) begin
      for (int k = 0; k < 4; k++) mregs[k] = tm[k];
      done_q.push_back(c + 6 * len + 1);
    end
    start    = 1'b1;
    prog_len = PW'(len);
    @(negedge clk);
    start    = 1'b0;
    prog_len = PW'($urandom_range(15));
  endtask

  task automatic wait_done(input int n0);
    int t = 0;
    while (done_cnt == n0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done_cnt, n0 + 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic verify_state(input string tag);
    for (int k = 0; k < 4; k++) check({tag, "_reg"}, 32'(regs[k]), 32'(mregs[k]));
    check({tag, "_result"}, 32'(result), exp_result);
    check({tag, "_wbq"}, wb_q.size(), 0);
    check({tag, "_phase"}, 32'(phase), 32'(PH_IDLE));
  endtask

  initial begin
    int n0;
    int ph_exp [8];
    ph_exp = '{0, 0, 0, 1, 1, 1, 2, 3};
    for (int i = 0; i < 16; i++) imem[i] = '0;
    for (int k = 0; k < 4; k++) set_reg(k, '0);

    // reset state
    @(negedge clk);
    check("rst_phase", 32'(phase), 3);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_wr_en", 32'(reg_wr_en), 0);
    check("rst_alu_en", 32'(alu_en), 0);
    check("rst_inst_addr", 32'(inst_addr), 0);
    check("rst_reg_addr", 32'(reg_addr), 0);
    check("rst_result", 32'(result), 0);
    check("rst_alu_in", 32'({alu_opcode, alu_in_1, alu_in_2}), 0);
    rst = 1'b1;
    @(negedge clk);

    // single instruction: R2 = R0 + R1
    set_reg(0, 4'd3);
    set_reg(1, 4'd4);
    imem[0] = {3'b000, 2'd2, 2'd0, 2'd1};
    n0 = done_cnt;
    alu_cnt = 0;
    launch(1, 1'b1);
    for (int k = 0; k < 8; k++) begin
      check("t1_phase", 32'(phase), ph_exp[k]);
      @(negedge clk);
    end
    check("t1_done_cnt", done_cnt, n0 + 1);
    check("t1_result", 32'(result), 7);
    check("t1_r2", 32'(regs[2]), 7);
    check("t1_alu_cnt", alu_cnt, 1);
    verify_state("t1");

    // three-instruction chain through R2
    imem[0] = {3'd0, 2'd2, 2'd0, 2'd1};
    imem[1] = {3'd1, 2'd2, 2'd2, 2'd0};
    imem[2] = {3'd4, 2'd3, 2'd2, 2'd1};
    set_reg(0, 4'd5);
    set_reg(1, 4'd9);
    n0 = done_cnt;
    launch(3, 1'b1);
    wait_done(n0);
    verify_state("t2");

    // empty program
    n0 = done_cnt;
    alu_cnt = 0;
    busy_cnt = 0;
    launch(0, 1'b1);
    wait_done(n0);
    check("t3_busy_cnt", busy_cnt, 1);
    check("t3_alu_cnt", alu_cnt, 0);
    verify_state("t3");

    // start re-asserted mid-run with a new length
    imem[0] = {3'd2, 2'd1, 2'd0, 2'd3};
    imem[1] = {3'd3, 2'd0, 2'd1, 2'd2};
    n0 = done_cnt;
    alu_cnt = 0;
    launch(2, 1'b1);
    start = 1'b1;
    prog_len = 4'd5;
    repeat (4) @(negedge clk);
    start = 1'b0;
    wait_done(n0);
    repeat (10) @(negedge clk);
    check("t4_done_cnt", done_cnt, n0 + 1);
    check("t4_alu_cnt", alu_cnt, 2);
    verify_state("t4");

    // reset during write-back: write dropped, no done
    imem[0] = {3'd6, 2'd3, 2'd3, 2'd0};
    n0 = done_cnt;
    launch(1, 1'b0);
    repeat (5) @(negedge clk);
    #2;
    check("t5_in_wb", 32'(reg_wr_en), 1);
    rst = 1'b0;
    #1;
    check("t5_wr_en", 32'(reg_wr_en), 0);
    check("t5_phase", 32'(phase), 3);
    check("t5_busy", 32'(busy), 0);
    exp_result = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_done_cnt", done_cnt, n0);
    verify_state("t5");
    n0 = done_cnt;
    launch(1, 1'b1);
    wait_done(n0);
    verify_state("t5b");

    // maximum program length
    for (int i = 0; i < 15; i++) imem[i] = IW'($urandom);
    n0 = done_cnt;
    max_pc = 0;
    launch(15, 1'b1);
    wait_done(n0);
    check("t6_max_pc", max_pc, 14);
    verify_state("t6");

    // a few random programs
    for (int p = 0; p < 3; p++) begin
      int len;
      len = $urandom_range(4, 1);
      for (int i = 0; i < len; i++) imem[i] = IW'($urandom);
      n0 = done_cnt;
      launch(len, 1'b1);
      wait_done(n0);
      verify_state("rnd");
    end

    check("final_doneq", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control FSM that runs a stored program on the CPU datapath. Per instruction it fetches from instruction memory, reads two operands through the single-port register file, fires the ALU, and writes the result back. It drives the 2-bit phase code: 00 load, 01 execute, 10 output, 11 idle. It sits inside cpu, between the instruction memory, the register file (cpu_registers) and the ALU.

Parameters:
DATA_W, 4, register/ALU data width
RADDR_W, 2, register file address width
OP_W, 3, ALU opcode width
PC_W, 4, instruction address width; instruction word width INST_W = OP_W + 3*RADDR_W (9 by default)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
start  in  1  run request; only sampled in IDLE
prog_len  in  PC_W  instruction count; sampled on accepted start
inst_addr  out  PC_W  instruction memory address (= pc)
inst_data  in  INST_W  instruction word; combinational read; fields {opcode[8:6], rd[5:4], rs1[3:2], rs2[1:0]}
reg_addr  out  RADDR_W  register file address
reg_rdata  in  DATA_W  register file read data; combinational
reg_wr_en  out  1  register write strobe
reg_wdata  out  DATA_W  register write data
alu_en  out  1  ALU enable
alu_opcode  out  OP_W  ALU opcode
alu_in_1  out  DATA_W  ALU operand 1
alu_in_2  out  DATA_W  ALU operand 2
alu_out  in  DATA_W  ALU result; registered, valid 1 cycle after alu_en
phase  out  2  phase code
busy  out  1  high in every state except IDLE
done  out  1  one-cycle completion pulse
result  out  DATA_W  last written-back value; held until next write-back or reset

Behaviour:
- Reset (rst=0, async): state IDLE. pc, ir, op_a, op_b, res, len_q, result all 0. Outputs: phase=11, busy=0, done=0, reg_wr_en=0, alu_en=0, all buses 0.
- States and phase codes: IDLE(11), FETCH(00), OPA(00), OPB(00), EXEC(01), AWAIT(01), WB(01), DONE(10).
- IDLE: on start=1, latch len_q=prog_len and clear pc. If prog_len!=0, go to FETCH; if prog_len==0, go to DONE with no memory or register activity.
- FETCH: inst_addr=pc. ir <= inst_data. Next state OPA.
- OPA: reg_addr=ir.rs1. op_a <= reg_rdata. Next state OPB.
- OPB: reg_addr=ir.rs2. op_b <= reg_rdata. Next state EXEC.
- EXEC: alu_en=1 for exactly this cycle. Next state AWAIT.
- AWAIT: res <= alu_out. Next state WB.
- WB: reg_wr_en=1, reg_addr=ir.rd, reg_wdata=res. result <= res. If pc==len_q-1, go to DONE; else pc <= pc+1 and go to FETCH.
- DONE: done=1 for this single cycle. Next state IDLE.
- alu_opcode, alu_in_1 and alu_in_2 always show ir.opcode, op_a and op_b. They stay stable through EXEC and AWAIT.
- reg_addr is 0 outside OPA, OPB and WB. inst_addr always equals pc.
- Latency: 6 cycles per instruction. N instructions: done asserts 6N+1 cycles after the start cycle. prog_len==0: done asserts on the cycle after start.
- start is ignored while busy. Changes to prog_len after acceptance have no effect.
- pc never wraps: maximum prog_len is 2^PC_W-1, and the last pc is len_q-1.
- rs1==rd or rs2==rd is legal. Reads complete before the write, so old values are used.
- Reset mid-run: immediate return to IDLE. Any in-flight WB write is dropped, and no done pulse is issued.

Decomposition:
- Shared package cpu_pkg holds:
  - the state enum;
  - the phase encodings PH_LOAD=00, PH_EXEC=01, PH_OUT=10, PH_IDLE=11;
  - the instruction field offsets and widths;
  - the INST_W derivation.
- The same phase constants replace the phase cases currently commented out in cpu.
- No sub-module: field extraction is plain slicing inside the FSM.

Test Plan:
- Single instruction: prog_len=1, inst[0]={op=000, rd=2, rs1=0, rs2=1}, R0=3, R1=4, model ALU add. Required: reg_wr_en 6 cycles after start with addr 2, data 7; result=7; done on cycle 7; phase sequence 00,00,00,01,01,01,10,11.
- Three-instruction chain: second and third instructions use R2 as rs1 → each reads the prior result. done at cycle 19. inst_addr steps 0, 1, 2.
- prog_len=0: start → done on the next cycle. No reg_wr_en or alu_en pulses; busy high for exactly 1 cycle.
- start re-asserted during a run with prog_len changed to 5: no effect. The original count completes and a single done pulse is issued.
- rst pulled low during WB: reg_wr_en drops immediately, register contents are unchanged, state is IDLE, phase=11, no done pulse. A new start then runs correctly.
- prog_len=15 (maximum): pc reaches 14 and does not wrap. done at cycle 91.
